// File: rtl/sbox_lut_engine.sv
// Multi-lane runtime-loadable S-box: LANES register tables, one parallel lookup per
// accepted beat, result registered behind a valid/ready stream with one-cycle latency.
module sbox_lut_engine #(
  parameter int IN_W      = 6,
  parameter int OUT_W     = 4,
  parameter int LANES     = 8,
  parameter int ADDR_MODE = 1,
  localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [LW-1:0]          cfg_lane,
  input  logic [IN_W-1:0]        cfg_idx,
  input  logic [OUT_W-1:0]       cfg_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [15:0]            beat_cnt
);

  localparam int DEPTH = 1 << IN_W;

  logic                   out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0] out_data_q, out_data_d;
  logic [15:0]            beat_cnt_q, beat_cnt_d;
  logic [LANES*OUT_W-1:0] lookup;
  logic                   accept, drain;

  // Blocking lookups during a write keeps every beat on a fully consistent table set.
  assign in_ready = !cfg_we && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [OUT_W-1:0] tbl_q [DEPTH];
      logic [IN_W-1:0]  din;
      logic [IN_W-1:0]  idx;

      assign din = in_data[gi*IN_W +: IN_W];

      // DES mapping: outer bits select the row, inner bits the column, row-major storage.
      if (ADDR_MODE == 1) begin : g_des
        assign idx = {din[IN_W-1], din[0], din[IN_W-2:1]};
      end else begin : g_dir
        assign idx = din;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else if (cfg_we && cfg_lane == LW'(gi)) begin
          tbl_q[cfg_idx] <= cfg_data;
        end
      end

      assign lookup[gi*OUT_W +: OUT_W] = tbl_q[idx];
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    beat_cnt_d  = beat_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    if (drain && beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_sbox_lut_engine.sv
// Directed bench: DES-mapped 8-lane instance plus a direct-mapped 6-lane instance
// sharing clock and reset.
module tb_sbox_lut_engine;

  logic clk, rst;

  // instance A: defaults (IN_W=6, OUT_W=4, LANES=8, ADDR_MODE=1)
  logic        a_cfg_we, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0]  a_cfg_lane;
  logic [5:0]  a_cfg_idx;
  logic [3:0]  a_cfg_data;
  logic [47:0] a_in_data;
  logic [31:0] a_out_data;
  logic [15:0] a_beat_cnt;

  // instance B: LANES=6, ADDR_MODE=0
  logic        b_cfg_we, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]  b_cfg_lane;
  logic [5:0]  b_cfg_idx;
  logic [3:0]  b_cfg_data;
  logic [35:0] b_in_data;
  logic [23:0] b_out_data;
  logic [15:0] b_beat_cnt;

  int checks = 0;
  int failures = 0;

  int s6 [64] = '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
                  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
                  9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
                  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13};

  sbox_lut_engine dut (
    .clk(clk), .rst(rst), .cfg_we(a_cfg_we), .cfg_lane(a_cfg_lane), .cfg_idx(a_cfg_idx),
    .cfg_data(a_cfg_data), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .beat_cnt(a_beat_cnt)
  );

  sbox_lut_engine #(.IN_W(6), .OUT_W(4), .LANES(6), .ADDR_MODE(0)) dut6 (
    .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_lane(b_cfg_lane), .cfg_idx(b_cfg_idx),
    .cfg_data(b_cfg_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .beat_cnt(b_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int lane, input int idx, input int data);
    a_cfg_we = 1'b1; a_cfg_lane = 3'(lane); a_cfg_idx = 6'(idx); a_cfg_data = 4'(data);
    step();
    a_cfg_we = 1'b0;
  endtask

  task automatic wr_b(input int lane, input int idx, input int data);
    b_cfg_we = 1'b1; b_cfg_lane = 3'(lane); b_cfg_idx = 6'(idx); b_cfg_data = 4'(data);
    step();
    b_cfg_we = 1'b0;
  endtask

  task automatic look_a(input logic [5:0] v);
    a_in_data = '0; a_in_data[5:0] = v;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    $display("lookup A lane0 in=%b out_valid=%0b out_data=%h", v, a_out_valid, a_out_data);
  endtask

  task automatic look_b(input logic [35:0] v);
    b_in_data = v;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    $display("lookup B in=%h out_valid=%0b out_data=%h", v, b_out_valid, b_out_data);
  endtask

  initial begin
    rst = 1'b1;
    a_cfg_we = 0; a_cfg_lane = 0; a_cfg_idx = 0; a_cfg_data = 0;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
    b_cfg_we = 0; b_cfg_lane = 0; b_cfg_idx = 0; b_cfg_data = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
    #2;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", a_out_data, 32'd0);
    chk("rst_beat_cnt", 32'(a_beat_cnt), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    step();
    rst = 1'b0;

    // DES S6 into lane 0 of instance A
    a_cfg_we = 1'b1;
    #1;
    chk("cfg_blocks_ready", 32'(a_in_ready), 32'd0);
    for (int i = 0; i < 64; i++) wr_a(0, i, s6[i]);
    look_a(6'b000000); chk("des_000000_valid", 32'(a_out_valid), 32'd1);
    chk("des_000000", a_out_data, 32'h0000000C);
    look_a(6'b000011); chk("des_000011", a_out_data, 32'h0000000F);
    look_a(6'b100001); chk("des_100001", a_out_data, 32'h00000004);
    look_a(6'b111111); chk("des_111111", a_out_data, 32'h0000000D);

    // direct mode, lane 2 table[i] = i ^ 4'hA on instance B
    for (int i = 0; i < 64; i++) wr_b(2, i, (i & 15) ^ 10);
    look_b({6'd5, 6'd5, 6'd5, 6'd5, 6'd5, 6'd5}); chk("dir_lane2_5", 32'(b_out_data), 32'h000F00);
    look_b({6'd0, 6'd0, 6'd0, 6'd63, 6'd7, 6'd9}); chk("dir_lane2_63", 32'(b_out_data), 32'h000500);

    // out-of-range lanes on the 6-lane instance must not alter anything
    wr_b(7, 5, 9);
    wr_b(6, 0, 3);
    look_b({6'd5, 6'd5, 6'd5, 6'd5, 6'd5, 6'd5}); chk("oor_idx5", 32'(b_out_data), 32'h000F00);
    look_b({6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}); chk("oor_idx0", 32'(b_out_data), 32'h000A00);

    // backpressure on instance A
    step();
    chk("cnt_before_bp", 32'(a_beat_cnt), 32'd4);
    a_out_ready = 1'b0;
    look_a(6'b000011);
    chk("bp_first", a_out_data, 32'h0000000F);
    a_in_valid = 1'b1; a_in_data = '0; a_in_data[5:0] = 6'b100001;
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_valid", 32'(a_out_valid), 32'd1);
      chk("bp_data", a_out_data, 32'h0000000F);
      $display("hold cycle %0d in_ready=%0b out_data=%h", c, a_in_ready, a_out_data);
      step();
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_in_ready), 32'd1);
    step();
    chk("bp_beat2", a_out_data, 32'h00000004);
    chk("bp_cnt5", 32'(a_beat_cnt), 32'd5);
    a_in_data[5:0] = 6'b111111;
    step();
    chk("bp_beat3", a_out_data, 32'h0000000D);
    chk("bp_cnt6", 32'(a_beat_cnt), 32'd6);
    a_in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(a_out_valid), 32'd0);
    chk("drain_hold", a_out_data, 32'h0000000D);
    chk("drain_cnt7", 32'(a_beat_cnt), 32'd7);

    // write and lookup presented together
    a_cfg_we = 1'b1; a_cfg_lane = 3'd0; a_cfg_idx = 6'd0; a_cfg_data = 4'd5;
    a_in_valid = 1'b1; a_in_data = '0;
    #1;
    chk("coll_in_ready", 32'(a_in_ready), 32'd0);
    step();
    a_cfg_we = 1'b0;
    chk("coll_no_accept", 32'(a_out_valid), 32'd0);
    step();
    a_in_valid = 1'b0;
    chk("coll_new_value", a_out_data, 32'h00000005);
    step();
    chk("coll_cnt8", 32'(a_beat_cnt), 32'd8);

    // async reset while a result is held
    a_out_ready = 1'b0;
    look_a(6'b111111);
    chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(a_out_valid), 32'd0);
    chk("arst_cnt", 32'(a_beat_cnt), 32'd0);
    chk("arst_data", a_out_data, 32'd0);
    step();
    rst = 1'b0;
    a_out_ready = 1'b1;
    look_a(6'b000000);
    chk("post_rst_valid", 32'(a_out_valid), 32'd1);
    chk("post_rst_cleared", a_out_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
